// File: rtl/udp_reg_ring_pkg.sv
// udp_reg_ring_pkg: shared widths, default return data and FSM encoding for the register ring initiator
package udp_reg_ring_pkg;
  localparam int UDP_REG_ADDR_WIDTH = 23;
  localparam int CPCI_NF2_DATA_WIDTH = 32;
  localparam logic [CPCI_NF2_DATA_WIDTH-1:0] UNCLAIMED_DATA_DEF = 32'hDEAD_BEEF;
  localparam logic [CPCI_NF2_DATA_WIDTH-1:0] TIMEOUT_DATA_DEF = 32'hDEAD_DEAD;
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_t;
endpackage

// File: rtl/udp_reg_timeout_timer.sv
// udp_reg_timeout_timer: 16-bit cycle counter with clear/enable, flags expiry at TIMEOUT-1
module udp_reg_timeout_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [15:0] count;
  // clear has priority; count only while enabled
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) count <= '0;
    else if (clr) count <= '0;
    else if (en) count <= count + 16'd1;
  assign expire = count == 16'(TIMEOUT - 1);
endmodule

// File: rtl/udp_reg_ring_initiator.sv
// udp_reg_ring_initiator: launches host register accesses onto the ring and returns data/status from the tail
module udp_reg_ring_initiator
  import udp_reg_ring_pkg::*;
#(
  parameter int UDP_REG_SRC_WIDTH = 2,
  parameter int SRC_ID = 0,
  parameter int TIMEOUT = 1024,
  parameter logic [CPCI_NF2_DATA_WIDTH-1:0] UNCLAIMED_DATA = UNCLAIMED_DATA_DEF,
  parameter logic [CPCI_NF2_DATA_WIDTH-1:0] TIMEOUT_DATA = TIMEOUT_DATA_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic core_reg_req,
  input  logic core_reg_rd_wr_L,
  input  logic [UDP_REG_ADDR_WIDTH-1:0] core_reg_addr,
  input  logic [CPCI_NF2_DATA_WIDTH-1:0] core_reg_wr_data,
  output logic core_reg_busy,
  output logic core_reg_ack,
  output logic [CPCI_NF2_DATA_WIDTH-1:0] core_reg_rd_data,
  output logic core_reg_err,
  output logic reg_req_out,
  output logic reg_ack_out,
  output logic reg_rd_wr_L_out,
  output logic [UDP_REG_ADDR_WIDTH-1:0] reg_addr_out,
  output logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0] reg_src_out,
  input  logic reg_req_in,
  input  logic reg_ack_in,
  input  logic reg_rd_wr_L_in,
  input  logic [UDP_REG_ADDR_WIDTH-1:0] reg_addr_in,
  input  logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0] reg_src_in
);
  localparam logic [UDP_REG_SRC_WIDTH-1:0] SRC = UDP_REG_SRC_WIDTH'(SRC_ID);
  state_t state, next_state;
  logic rd_wr_q;
  logic [UDP_REG_ADDR_WIDTH-1:0] addr_q;
  logic match, expire, launch, finish;
  assign match = reg_req_in && reg_src_in == SRC && reg_addr_in == addr_q && reg_rd_wr_L_in == rd_wr_q;
  assign launch = next_state == S_LAUNCH;
  assign finish = state == S_WAIT && (match || expire);
  assign reg_ack_out = 1'b0;
  // timer starts at 0 in LAUNCH so expiry lands TIMEOUT cycles after the launch cycle
  udp_reg_timeout_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk),
    .reset_n(reset_n),
    .clr(state == S_IDLE),
    .en(state == S_LAUNCH || state == S_WAIT),
    .expire(expire)
  );
  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= S_IDLE;
    else state <= next_state;
  // next-state: requests only accepted in IDLE, match beats expiry
  always_comb
    next_state = state == S_IDLE ? (core_reg_req ? S_LAUNCH : S_IDLE) :
                 state == S_LAUNCH ? S_WAIT :
                 state == S_WAIT ? (match || expire ? S_DONE : S_WAIT) : S_IDLE;
  // capture direction and address of the accepted request for return matching
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rd_wr_q <= 1'b0;
      addr_q <= '0;
    end else if (state == S_IDLE && core_reg_req) begin
      rd_wr_q <= core_reg_rd_wr_L;
      addr_q <= core_reg_addr;
    end
  // registered outputs derived from the upcoming state
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      core_reg_busy <= 1'b0;
      core_reg_ack <= 1'b0;
      core_reg_rd_data <= '0;
      core_reg_err <= 1'b0;
      reg_req_out <= 1'b0;
      reg_rd_wr_L_out <= 1'b0;
      reg_addr_out <= '0;
      reg_data_out <= '0;
      reg_src_out <= '0;
    end else begin
      core_reg_busy <= next_state != S_IDLE;
      core_reg_ack <= next_state == S_DONE;
      if (finish) begin
        core_reg_rd_data <= match ? (reg_ack_in ? (rd_wr_q ? reg_data_in : '0) : UNCLAIMED_DATA) : TIMEOUT_DATA;
        core_reg_err <= !(match && reg_ack_in);
      end
      reg_req_out <= launch;
      reg_rd_wr_L_out <= launch && core_reg_rd_wr_L;
      reg_addr_out <= launch ? core_reg_addr : '0;
      reg_data_out <= launch && !core_reg_rd_wr_L ? core_reg_wr_data : '0;
      reg_src_out <= launch ? SRC : '0;
    end
endmodule

// File: tb/tb_udp_reg_ring_initiator.sv
// tb_udp_reg_ring_initiator: table-driven ring transactions with a result scoreboard and reset/late-return sequences
module tb_udp_reg_ring_initiator;
  import udp_reg_ring_pkg::*;
  localparam int AW = UDP_REG_ADDR_WIDTH;
  localparam int DW = CPCI_NF2_DATA_WIDTH;
  localparam int TMO = 16;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic core_reg_req = 1'b0, core_reg_rd_wr_L = 1'b0;
  logic [AW-1:0] core_reg_addr = '0;
  logic [DW-1:0] core_reg_wr_data = '0;
  logic core_reg_busy, core_reg_ack, core_reg_err;
  logic [DW-1:0] core_reg_rd_data;
  logic reg_req_out, reg_ack_out, reg_rd_wr_L_out;
  logic [AW-1:0] reg_addr_out;
  logic [DW-1:0] reg_data_out;
  logic [1:0] reg_src_out;
  logic reg_req_in = 1'b0, reg_ack_in = 1'b0, reg_rd_wr_L_in = 1'b0;
  logic [AW-1:0] reg_addr_in = '0;
  logic [DW-1:0] reg_data_in = '0;
  logic [1:0] reg_src_in = '0;
  always #5 clk = ~clk;
  udp_reg_ring_initiator #(.UDP_REG_SRC_WIDTH(2), .SRC_ID(0), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .core_reg_req(core_reg_req), .core_reg_rd_wr_L(core_reg_rd_wr_L),
    .core_reg_addr(core_reg_addr), .core_reg_wr_data(core_reg_wr_data),
    .core_reg_busy(core_reg_busy), .core_reg_ack(core_reg_ack),
    .core_reg_rd_data(core_reg_rd_data), .core_reg_err(core_reg_err),
    .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out), .reg_rd_wr_L_out(reg_rd_wr_L_out),
    .reg_addr_out(reg_addr_out), .reg_data_out(reg_data_out), .reg_src_out(reg_src_out),
    .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in), .reg_rd_wr_L_in(reg_rd_wr_L_in),
    .reg_addr_in(reg_addr_in), .reg_data_in(reg_data_in), .reg_src_in(reg_src_in)
  );
  typedef struct {
    logic rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int mode;
    int delay;
    logic [DW-1:0] ret;
    logic stray;
  } vec_t;
  typedef struct {
    logic [DW-1:0] data;
    logic err;
  } exp_t;
  vec_t vecs[9];
  exp_t sb[$];
  exp_t got;
  int applied = 0;
  int miscompares = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic exp_t model(input vec_t v);
    exp_t e;
    if (v.mode == 2) begin
      e.data = 32'hDEAD_DEAD;
      e.err = 1'b1;
    end else if (v.mode == 1) begin
      e.data = 32'hDEAD_BEEF;
      e.err = 1'b1;
    end else begin
      e.data = v.rd ? v.ret : '0;
      e.err = 1'b0;
    end
    return e;
  endfunction
  always @(negedge clk)
    if (reset_n && core_reg_ack) begin
      if (sb.size() == 0) begin
        applied++;
        miscompares++;
        $display("FAIL unexpected_ack: got ack=1 rd_data=%h expected no ack", core_reg_rd_data);
      end else begin
        got = sb.pop_front();
        check("ack_rd_data", core_reg_rd_data, got.data);
        check("ack_err", 32'(core_reg_err), 32'(got.err));
      end
    end
  task automatic drive_ret(input logic rd, input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic ack, input logic [1:0] src);
    reg_req_in = 1'b1;
    reg_ack_in = ack;
    reg_rd_wr_L_in = rd;
    reg_addr_in = addr;
    reg_data_in = data;
    reg_src_in = src;
  endtask
  task automatic clear_ret();
    reg_req_in = 1'b0;
    reg_ack_in = 1'b0;
    reg_rd_wr_L_in = 1'b0;
    reg_addr_in = '0;
    reg_data_in = '0;
    reg_src_in = '0;
  endtask
  task automatic run_vec(input vec_t v);
    exp_t e;
    int n;
    logic done;
    @(negedge clk);
    core_reg_req = 1'b1;
    core_reg_rd_wr_L = v.rd;
    core_reg_addr = v.addr;
    core_reg_wr_data = v.wdata;
    e = model(v);
    sb.push_back(e);
    @(negedge clk);
    core_reg_req = 1'b0;
    core_reg_addr = ~v.addr;
    core_reg_wr_data = $urandom;
    check("head_req", 32'(reg_req_out), 1);
    check("head_ack", 32'(reg_ack_out), 0);
    check("head_rd_wr", 32'(reg_rd_wr_L_out), 32'(v.rd));
    check("head_addr", 32'(reg_addr_out), 32'(v.addr));
    check("head_data", reg_data_out, v.rd ? 32'h0 : v.wdata);
    check("head_src", 32'(reg_src_out), 0);
    check("busy_launch", 32'(core_reg_busy), 1);
    n = 0;
    done = 1'b0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      clear_ret();
      core_reg_req = 1'b0;
      if (v.mode != 2 && n == v.delay) drive_ret(v.rd, v.addr, v.ret, v.mode == 0, 2'd0);
      if (v.stray && n == 2) drive_ret(v.rd, v.addr, 32'h5555_AAAA, 1'b1, 2'd1);
      if (v.stray && n == 3) begin
        core_reg_req = 1'b1;
        core_reg_rd_wr_L = 1'b1;
        core_reg_addr = v.addr + 1;
      end
      if (n == 1) check("head_req_drop", 32'(reg_req_out), 0);
      done = core_reg_ack;
    end
    check("ack_latency", 32'(n), v.mode == 2 ? 32'(TMO) : 32'(v.delay + 1));
    check("busy_with_ack", 32'(core_reg_busy), 1);
    @(negedge clk);
    clear_ret();
    check("ack_pulse", 32'(core_reg_ack), 0);
    check("busy_idle", 32'(core_reg_busy), 0);
    check("rd_data_hold", core_reg_rd_data, e.data);
  endtask
  initial begin
    vecs[0] = '{1'b1, 23'h000040, 32'h0, 0, 5, 32'h1234_5678, 1'b0};
    vecs[1] = '{1'b0, 23'h000044, 32'hCAFE_F00D, 0, 3, 32'hCAFE_F00D, 1'b0};
    vecs[2] = '{1'b1, 23'h000048, 32'h0, 1, 4, 32'h0, 1'b0};
    vecs[3] = '{1'b1, 23'h00004C, 32'h0, 2, 0, 32'h0, 1'b0};
    vecs[4] = '{1'b1, 23'h000050, 32'h0, 0, 2, 32'hA5A5_0001, 1'b0};
    vecs[5] = '{1'b1, 23'h000054, 32'h0, 0, 8, 32'h0BAD_F00D, 1'b1};
    vecs[6] = '{1'b0, 23'h000058, 32'h1111_2222, 1, 1, 32'h0, 1'b0};
    vecs[7] = '{1'b1, 23'h00005C, 32'h0, 0, 15, 32'h7777_1111, 1'b0};
    vecs[8] = '{1'b1, 23'h000064, 32'h0, 0, 4, 32'h0246_8ACE, 1'b0};
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(core_reg_busy), 0);
    check("rst_ack", 32'(core_reg_ack), 0);
    check("rst_rd_data", core_reg_rd_data, 0);
    check("rst_err", 32'(core_reg_err), 0);
    check("rst_req_out", 32'(reg_req_out), 0);
    check("rst_addr_out", 32'(reg_addr_out), 0);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i]);
      if (i == 3) begin
        repeat (4) @(negedge clk);
        drive_ret(1'b1, vecs[3].addr, 32'h9999_9999, 1'b1, 2'd0);
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          clear_ret();
          check("late_no_ack", 32'(core_reg_ack), 0);
        end
        check("late_no_busy", 32'(core_reg_busy), 0);
      end
    end
    @(negedge clk);
    core_reg_req = 1'b1;
    core_reg_rd_wr_L = 1'b1;
    core_reg_addr = 23'h000060;
    @(negedge clk);
    core_reg_req = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(core_reg_busy), 0);
    check("mid_rst_rd_data", core_reg_rd_data, 0);
    check("mid_rst_err", 32'(core_reg_err), 0);
    check("mid_rst_req_out", 32'(reg_req_out), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    drive_ret(1'b1, 23'h000060, 32'h3333_3333, 1'b1, 2'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      clear_ret();
      check("post_rst_no_ack", 32'(core_reg_ack), 0);
    end
    run_vec(vecs[8]);
    check("sb_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
